// File: rtl/pool_flatten_engine.sv
// pool_flatten_engine
//   Reads 2x2 blocks of per-channel convolution results from the layer-0 memories,
//   optionally applies ReLU, reduces each block by max or floor-average, and writes
//   the result both to the per-channel pooled map (layer 1) and to the
//   channel-interleaved flattened vector (layer 2).
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   ready     in   start request, sampled only while idle
//   mode      in   [0] 0 = max, 1 = average; [1] ReLU before pooling; latched at start
//   busy      out  high from start until the last write has been issued
//   crd       out  read strobe
//   caddr_rd  out  read address
//   cdata_rd  in   read data, valid one cycle after the request
//   cwr       out  write strobe
//   caddr_wr  out  write address
//   cdata_wr  out  write data
//   csel      out  memory select: input k = 1+k, pooled k = 1+CH+k, flatten = 1+2*CH
//
// Every output comes straight from a flop; next-state logic computes the values the
// outputs take in the state being entered.

module pool_flatten_engine #(
   parameter int unsigned DATA_W = 20,
   parameter int unsigned IMG_W  = 64,
   parameter int unsigned CH     = 2,
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ready,
   input  logic [1:0]        mode,
   output logic              busy,
   output logic              crd,
   output logic [ADDR_W-1:0] caddr_rd,
   input  logic [DATA_W-1:0] cdata_rd,
   output logic              cwr,
   output logic [ADDR_W-1:0] caddr_wr,
   output logic [DATA_W-1:0] cdata_wr,
   output logic [2:0]        csel
);

   localparam int unsigned LogW = $clog2(IMG_W);
   // Pooled pixel index: upper half is the pooled row, lower half the pooled column.
   localparam int unsigned PixW = 2 * (LogW - 1);
   // Two guard bits keep the four-sample sum exact.
   localparam int unsigned AccW = DATA_W + 2;

   localparam logic [PixW-1:0]   LastPix     = '1;
   localparam logic [1:0]        LastCh      = 2'(CH - 1);
   localparam logic [2:0]        PoolSelBase = 3'(1 + CH);
   localparam logic [2:0]        FlatSel     = 3'(1 + 2 * CH);
   localparam logic [ADDR_W-1:0] ChA         = ADDR_W'(CH);

   typedef enum logic [2:0] {
      StIdle,
      StRd0,
      StRd1,
      StRd2,
      StRd3,
      StCalc,
      StWpool,
      StWflat
   } state_e;

   state_e                  state_q, state_d;
   logic [PixW-1:0]         pix_q, pix_d;
   logic [1:0]              ch_q, ch_d;
   logic [1:0]              mode_q, mode_d;
   logic signed [AccW-1:0]  acc_q, acc_d;
   logic                    busy_q, busy_d;
   logic                    crd_q, crd_d;
   logic                    cwr_q, cwr_d;
   logic [2:0]              csel_q, csel_d;
   logic [ADDR_W-1:0]       caddr_rd_q, caddr_rd_d;
   logic [ADDR_W-1:0]       caddr_wr_q, caddr_wr_d;
   logic [DATA_W-1:0]       cdata_wr_q, cdata_wr_d;

   // Input-map address of a block corner. Since IMG_W is a power of two, the pooled
   // row/column just get the row/column offset bit appended as their new LSB.
   function automatic logic [ADDR_W-1:0] rd_addr(input logic [PixW-1:0] pix,
                                                 input logic dy, input logic dx);
      logic [2*LogW-1:0] a;
      a = {pix[PixW-1:LogW-1], dy, pix[LogW-2:0], dx};
      return ADDR_W'(a);
   endfunction

   // Sample path: optional ReLU, sign extension, fold into the running value.
   logic signed [AccW-1:0] smp_x;
   logic signed [AccW-1:0] fold;
   logic signed [AccW-1:0] res_sh;
   logic [DATA_W-1:0]      result;

   always_comb begin
      if (mode_q[1] && cdata_rd[DATA_W-1]) begin
         smp_x = '0;
      end else begin
         smp_x = {{2{cdata_rd[DATA_W-1]}}, cdata_rd};
      end

      if (mode_q[0]) begin
         fold = acc_q + smp_x;
      end else if (smp_x > acc_q) begin
         fold = smp_x;
      end else begin
         fold = acc_q;
      end

      // Arithmetic shift floors the average for negative sums too.
      res_sh = fold >>> 2;
      result = mode_q[0] ? res_sh[DATA_W-1:0] : fold[DATA_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      pix_d      = pix_q;
      ch_d       = ch_q;
      mode_d     = mode_q;
      acc_d      = acc_q;
      busy_d     = busy_q;
      crd_d      = 1'b0;
      cwr_d      = 1'b0;
      csel_d     = csel_q;
      caddr_rd_d = caddr_rd_q;
      caddr_wr_d = caddr_wr_q;
      cdata_wr_d = cdata_wr_q;

      case (state_q)
         StIdle: begin
            busy_d     = 1'b0;
            csel_d     = '0;
            caddr_rd_d = '0;
            caddr_wr_d = '0;
            cdata_wr_d = '0;
            if (ready) begin
               state_d    = StRd0;
               busy_d     = 1'b1;
               mode_d     = mode;
               pix_d      = '0;
               ch_d       = '0;
               crd_d      = 1'b1;
               csel_d     = 3'd1;
               caddr_rd_d = '0;
            end
         end

         StRd0: begin
            state_d    = StRd1;
            crd_d      = 1'b1;
            caddr_rd_d = rd_addr(pix_q, 1'b0, 1'b1);
         end

         // RD0 data arrives now; it seeds both the max and the sum.
         StRd1: begin
            state_d    = StRd2;
            acc_d      = smp_x;
            crd_d      = 1'b1;
            caddr_rd_d = rd_addr(pix_q, 1'b1, 1'b0);
         end

         StRd2: begin
            state_d    = StRd3;
            acc_d      = fold;
            crd_d      = 1'b1;
            caddr_rd_d = rd_addr(pix_q, 1'b1, 1'b1);
         end

         StRd3: begin
            state_d = StCalc;
            acc_d   = fold;
         end

         // Last sample lands here; the finished result goes straight to cdata_wr.
         StCalc: begin
            state_d    = StWpool;
            cdata_wr_d = result;
            cwr_d      = 1'b1;
            csel_d     = PoolSelBase + 3'(ch_q);
            caddr_wr_d = ADDR_W'(pix_q);
         end

         StWpool: begin
            state_d    = StWflat;
            cwr_d      = 1'b1;
            csel_d     = FlatSel;
            caddr_wr_d = ADDR_W'(pix_q) * ChA + ADDR_W'(ch_q);
         end

         StWflat: begin
            if ((ch_q != LastCh) || (pix_q != LastPix)) begin
               if (ch_q != LastCh) begin
                  ch_d = ch_q + 2'd1;
               end else begin
                  ch_d  = '0;
                  pix_d = pix_q + PixW'(1);
               end
               state_d    = StRd0;
               crd_d      = 1'b1;
               csel_d     = 3'(ch_d) + 3'd1;
               caddr_rd_d = rd_addr(pix_d, 1'b0, 1'b0);
            end else begin
               state_d    = StIdle;
               busy_d     = 1'b0;
               csel_d     = '0;
               caddr_rd_d = '0;
               caddr_wr_d = '0;
               cdata_wr_d = '0;
            end
         end

         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         pix_q      <= '0;
         ch_q       <= '0;
         mode_q     <= '0;
         acc_q      <= '0;
         busy_q     <= 1'b0;
         crd_q      <= 1'b0;
         cwr_q      <= 1'b0;
         csel_q     <= '0;
         caddr_rd_q <= '0;
         caddr_wr_q <= '0;
         cdata_wr_q <= '0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         ch_q       <= ch_d;
         mode_q     <= mode_d;
         acc_q      <= acc_d;
         busy_q     <= busy_d;
         crd_q      <= crd_d;
         cwr_q      <= cwr_d;
         csel_q     <= csel_d;
         caddr_rd_q <= caddr_rd_d;
         caddr_wr_q <= caddr_wr_d;
         cdata_wr_q <= cdata_wr_d;
      end
   end

   assign busy     = busy_q;
   assign crd      = crd_q;
   assign cwr      = cwr_q;
   assign csel     = csel_q;
   assign caddr_rd = caddr_rd_q;
   assign caddr_wr = caddr_wr_q;
   assign cdata_wr = cdata_wr_q;

endmodule
